// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready inter-stage pipeline register with optional skid entry and stall/bubble counters
module pipe_stage_reg #(
    parameter int               DATA_W   = 72,
    parameter int               PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = 32'h0000_3000,
    parameter int               SKID     = 1,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_regwrite,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_SKID_FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q;
    logic                in_ready_q;
    logic [PC_W-1:0]     main_pc_q;
    logic [DATA_W-1:0]   main_data_q;
    logic                main_rw_q;
    logic [PC_W-1:0]     skid_pc_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic                skid_rw_q;
    logic [CNT_W-1:0]    stall_q;
    logic [CNT_W-1:0]    stall_d;
    logic [CNT_W-1:0]    bubble_q;
    logic [CNT_W-1:0]    bubble_d;
    logic                in_xfer;
    logic                out_xfer;

    // The main entry is always the one presented downstream; the skid entry
    // only ever holds the younger of two instructions.
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_pc       = main_pc_q;
    assign out_data     = main_data_q;
    assign out_regwrite = main_rw_q & out_valid;

    // With a skid entry the ready is registered so out_ready never reaches
    // in_ready combinationally; without one it must look at out_ready.
    assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy state machine with main/skid storage and registered in_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_pc_q   <= RESET_PC;
            main_data_q <= '0;
            main_rw_q   <= 1'b0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            skid_rw_q   <= 1'b0;
        end else if (flush) begin
            // Stale main payload is kept on purpose; only validity is killed.
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_pc_q   <= in_pc;
                        main_data_q <= in_data;
                        main_rw_q   <= in_regwrite;
                        state_q     <= ST_FULL;
                    end
                    in_ready_q <= 1'b1;
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_pc_q   <= in_pc;
                        main_data_q <= in_data;
                        main_rw_q   <= in_regwrite;
                        in_ready_q  <= 1'b1;
                    end else if (out_xfer) begin
                        state_q    <= ST_EMPTY;
                        in_ready_q <= 1'b1;
                    end else if (in_xfer && (SKID != 0)) begin
                        skid_pc_q   <= in_pc;
                        skid_data_q <= in_data;
                        skid_rw_q   <= in_regwrite;
                        state_q     <= ST_SKID_FULL;
                        in_ready_q  <= 1'b0;
                    end
                end
                ST_SKID_FULL: begin
                    if (out_xfer) begin
                        main_pc_q   <= skid_pc_q;
                        main_data_q <= skid_data_q;
                        main_rw_q   <= skid_rw_q;
                        state_q     <= ST_FULL;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating increments based on the pre-edge output handshake
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
        if (!out_valid && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    // Counters run through flush cycles and clear only on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - checks pipe_stage_reg against a queue-based reference model
module tb_pipe_stage_reg;

    localparam logic [31:0] RPC = 32'h0000_3000;

    typedef struct {
        logic [31:0] pc;
        logic [71:0] data;
        logic        rw;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, in_regwrite;
    logic [31:0] in_pc;
    logic [71:0] in_data;

    logic        rdy1, val1, rw1;
    logic [31:0] pc1;
    logic [71:0] dat1;
    logic [15:0] st1, bu1;
    logic        rdy4, val4, rw4;
    logic [31:0] pc4;
    logic [71:0] dat4;
    logic [3:0]  st4, bu4;
    logic        rdy0, val0, rw0;
    logic [31:0] pc0;
    logic [71:0] dat0;
    logic [15:0] st0, bu0;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    ent_t q1[$];
    ent_t q0[$];
    ent_t last1, last0;
    int   m_st1, m_bu1, m_st4, m_bu4, m_st0, m_bu0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_pc(in_pc), .in_data(in_data), .in_regwrite(in_regwrite), .out_valid(val1),
        .out_ready(out_ready), .out_pc(pc1), .out_data(dat1), .out_regwrite(rw1),
        .stall_cnt(st1), .bubble_cnt(bu1));

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_pc(in_pc), .in_data(in_data), .in_regwrite(in_regwrite), .out_valid(val4),
        .out_ready(out_ready), .out_pc(pc4), .out_data(dat4), .out_regwrite(rw4),
        .stall_cnt(st4), .bubble_cnt(bu4));

    pipe_stage_reg #(.SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_pc(in_pc), .in_data(in_data), .in_regwrite(in_regwrite), .out_valid(val0),
        .out_ready(out_ready), .out_pc(pc0), .out_data(dat0), .out_regwrite(rw0),
        .stall_cnt(st0), .bubble_cnt(bu0));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    // One clock: pre-edge ready checks, model update at the edge, post-edge output checks.
    task automatic tick();
        bit   mr1, mr0, xi1, xo1, xi0, xo0;
        ent_t e;
        #1;
        mr1 = (q1.size() < 2);
        mr0 = (q0.size() == 0) || out_ready;
        if (started) begin
            chk("in_ready_skid", rdy1, mr1);
            chk("in_ready_skid_c4", rdy4, mr1);
            chk("in_ready_noskid", rdy0, mr0);
        end
        xi1 = in_valid && mr1;
        xo1 = (q1.size() > 0) && out_ready;
        xi0 = in_valid && mr0;
        xo0 = (q0.size() > 0) && out_ready;
        e.pc = in_pc; e.data = in_data; e.rw = in_regwrite;
        @(posedge clk);
        if (reset) begin
            q1.delete(); q0.delete();
            last1.pc = RPC; last1.data = '0; last1.rw = 1'b0;
            last0 = last1;
            m_st1 = 0; m_bu1 = 0; m_st4 = 0; m_bu4 = 0; m_st0 = 0; m_bu0 = 0;
            started = 1;
        end else begin
            if (q1.size() > 0 && !out_ready) begin m_st1 = sat(m_st1, 16); m_st4 = sat(m_st4, 4); end
            if (q1.size() == 0) begin m_bu1 = sat(m_bu1, 16); m_bu4 = sat(m_bu4, 4); end
            if (q0.size() > 0 && !out_ready) m_st0 = sat(m_st0, 16);
            if (q0.size() == 0) m_bu0 = sat(m_bu0, 16);
            if (flush) begin
                q1.delete(); q0.delete();
            end else begin
                if (xo1) void'(q1.pop_front());
                if (xi1) q1.push_back(e);
                if (xo0) void'(q0.pop_front());
                if (xi0) q0.push_back(e);
            end
            if (q1.size() > 0) last1 = q1[0];
            if (q0.size() > 0) last0 = q0[0];
        end
        #1;
        if (started) begin
            chk("valid_skid", val1, q1.size() > 0);
            chk("pc_skid", pc1, last1.pc);
            chk("data_skid", dat1, last1.data);
            chk("rw_skid", rw1, (q1.size() > 0) && last1.rw);
            chk("stall_skid", st1, m_st1);
            chk("bubble_skid", bu1, m_bu1);
            chk("valid_c4", val4, q1.size() > 0);
            chk("stall_c4", st4, m_st4);
            chk("bubble_c4", bu4, m_bu4);
            chk("valid_noskid", val0, q0.size() > 0);
            chk("pc_noskid", pc0, last0.pc);
            chk("data_noskid", dat0, last0.data);
            chk("rw_noskid", rw0, (q0.size() > 0) && last0.rw);
            chk("stall_noskid", st0, m_st0);
            chk("bubble_noskid", bu0, m_bu0);
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic rw);
        in_valid    = v;
        in_pc       = pc;
        in_data     = {8'hA5, 32'h0, pc};
        in_regwrite = rw;
    endtask

    initial begin
        logic [95:0] rnd;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        offer(1'b0, 32'h0, 1'b0);

        // reset then idle
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_valid", val1, 1'b0);
        chk("idle_pc", pc1, 32'h3000);
        chk("idle_rw", rw1, 1'b0);
        chk("idle_bubble", bu1, 16'd3);
        chk("idle_ready", rdy1, 1'b1);

        // streaming with 1-cycle latency
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h3000 + 32'(4 * i), 1'b1);
            tick();
            chk("stream_pc", pc1, 32'h3000 + 32'(4 * i));
            chk("stream_valid", val1, 1'b1);
        end
        offer(1'b0, 32'h0, 1'b0);
        tick();
        chk("stream_stall", st1, 16'd0);

        // skid fill under stall, then drain in order
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 32'h3000, 1'b1); tick();
        offer(1'b1, 32'h3004, 1'b0); tick();
        chk("skid_ready_low", rdy1, 1'b0);
        chk("skid_pc_held", pc1, 32'h3000);
        offer(1'b0, 32'h0, 1'b0);
        repeat (3) tick();
        chk("skid_stall4", st1, 16'd4);
        out_ready = 1'b1;
        tick();
        chk("drain_pc_b", pc1, 32'h3004);
        chk("drain_ready", rdy1, 1'b1);
        tick();
        chk("drain_empty", val1, 1'b0);

        // flush while skid is full with an input offered
        out_ready = 1'b0;
        offer(1'b1, 32'h3010, 1'b1); tick();
        offer(1'b1, 32'h3014, 1'b1); tick();
        flush = 1'b1;
        offer(1'b1, 32'h3100, 1'b1); tick();
        flush = 1'b0;
        chk("flush_valid", val1, 1'b0);
        chk("flush_rw", rw1, 1'b0);
        chk("flush_ready", rdy1, 1'b1);
        offer(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("flush_no_c", val1, 1'b0);

        // reset dominates flush and a stalled full entry
        offer(1'b1, 32'h3200, 1'b1); tick();
        offer(1'b0, 32'h0, 1'b0);
        out_ready = 1'b0; flush = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        chk("rst_pc", pc1, 32'h3000);
        chk("rst_data", dat1, 72'h0);
        chk("rst_stall", st1, 16'd0);
        chk("rst_bubble", bu1, 16'd0);

        // long stall saturates the narrow counter only
        out_ready = 1'b1;
        offer(1'b1, 32'h3300, 1'b0); tick();
        offer(1'b0, 32'h0, 1'b0);
        out_ready = 1'b0;
        repeat (20) tick();
        chk("sat_c4", st4, 4'd15);
        chk("sat_c16", st1, 16'd20);
        out_ready = 1'b1;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rnd         = {$urandom(), $urandom(), $urandom()};
            in_valid    = ($urandom_range(0, 3) != 0);
            in_pc       = rnd[95:64];
            in_data     = rnd[71:0];
            in_regwrite = rnd[5];
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 29) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
